// File: rtl/spi_flash_word_reader.sv
// Reads one 32-bit little-endian word from SPI NOR flash (mode 0).
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_word_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] word_address,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        CLK,
    output logic        CS_N,
    output logic        MOSI,
    input  logic        MISO
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DUMMY,
        DATA
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sreg_q, sreg_d;
    logic [31:0] rcv_q, rcv_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;

    // State and datapath registers; reset aborts any transfer at once
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            rcv_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rcv_q   <= rcv_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: sclk_q doubles as the bit phase (0 = low, 1 = high)
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rcv_d   = rcv_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                if (rstrb) begin
                    sreg_d  = {CMD_BYTE, 2'b00, word_address, 2'b00};
                    mosi_d  = CMD_BYTE[7];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = CMD;
                end
            end
            default: begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    cnt_d  = cnt_q + 5'd1;
                    unique case (state_q)
                        CMD: begin
                            sreg_d = {sreg_q[30:0], 1'b0};
                            mosi_d = sreg_q[30];
                            if (cnt_q == 5'd31) begin
                                cnt_d  = '0;
                                mosi_d = 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
                                state_d = DUMMY;
`else
                                state_d = DATA;
`endif
                            end
                        end
                        DUMMY: begin
                            if (cnt_q == 5'd7) begin
                                cnt_d   = '0;
                                state_d = DATA;
                            end
                        end
                        DATA: begin
                            rcv_d = {rcv_q[30:0], MISO};
                            if (cnt_q == 5'd31) begin
                                rdata_d = {rcv_d[7:0], rcv_d[15:8],
                                           rcv_d[23:16], rcv_d[31:24]};
                                cs_n_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    assign rdata = rdata_q;
    assign rbusy = busy_q;
    assign CLK   = sclk_q;
    assign CS_N  = cs_n_q;
    assign MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Directed self-checking bench for spi_flash_word_reader.
// Build with SPI_FLASH_FAST_READ_EN to exercise the FAST READ variant.
module tb_spi_flash_word_reader;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam int BUSY   = 144;
    localparam int RISES  = 72;
    localparam int DSTART = 41;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam int BUSY   = 128;
    localparam int RISES  = 64;
    localparam int DSTART = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] word_address = '0;
    logic        rstrb = 1'b0;
    logic [31:0] rdata;
    logic        rbusy;
    logic        CLK;
    logic        CS_N;
    logic        MOSI;
    logic        MISO = 1'b0;

    int checks = 0;
    int errors = 0;
    int n;
    int rises = 0;
    int total_rises = 0;
    int bad_clk = 0;
    logic [31:0] mosi_cap = '0;
    logic [31:0] flash_word = '0;

    spi_flash_word_reader dut (
        .clk(clk), .reset(reset), .word_address(word_address),
        .rstrb(rstrb), .rdata(rdata), .rbusy(rbusy), .CLK(CLK),
        .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Flash model: capture command on CLK rise, present data after it
    always @(negedge CS_N or posedge CLK) begin
        if (!CLK) begin
            rises = 0;
            mosi_cap = '0;
        end else begin
            rises = rises + 1;
            if (rises <= 32) mosi_cap = {mosi_cap[30:0], MOSI};
            if (rises >= DSTART && rises < DSTART + 32)
                MISO = flash_word[31 - (rises - DSTART)];
        end
    end

    // Watch for SCLK activity while deselected
    always @(posedge CLK) begin
        total_rises = total_rises + 1;
        if (CS_N) bad_clk = bad_clk + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_read(input logic [19:0] a, input int pulse_at);
        @(negedge clk);
        word_address = a;
        rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0;
        chk("accept_busy", 32'(rbusy), 32'd1);
        chk("accept_csn", 32'(CS_N), 32'd0);
        n = 0;
        while (rbusy === 1'b1 && n < 400) begin
            n++;
            rstrb = (n == pulse_at);
            @(negedge clk);
        end
        rstrb = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_csn", 32'(CS_N), 32'd1);
        chk("rst_clk", 32'(CLK), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(rbusy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        repeat (10) @(negedge clk);
        chk("idle_rises", 32'(total_rises), 32'd0);
        chk("idle_csn", 32'(CS_N), 32'd1);
        chk("idle_busy", 32'(rbusy), 32'd0);

        // Abort by reset at E+70 before any word has completed
        flash_word = 32'h11223344;
        @(negedge clk);
        word_address = 20'h00001;
        rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0;
        repeat (69) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_csn", 32'(CS_N), 32'd1);
        chk("abort_busy", 32'(rbusy), 32'd0);
        chk("abort_clk", 32'(CLK), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_stay", 32'(rbusy), 32'd0);

        // Plain read of word 1
        flash_word = 32'h11223344;
        run_read(20'h00001, 0);
        chk("a_busy_len", 32'(n), 32'(BUSY));
        chk("a_rdata", rdata, 32'h44332211);
        chk("a_mosi", mosi_cap, {CMD, 24'h000004});
        chk("a_rises", 32'(rises), 32'(RISES));
        chk("a_csn_end", 32'(CS_N), 32'd1);

        // Top of the window
        flash_word = 32'hA55A0FF0;
        run_read(20'hFFFFF, 0);
        chk("b_busy_len", 32'(n), 32'(BUSY));
        chk("b_rdata", rdata, 32'hF00F5AA5);
        chk("b_mosi", mosi_cap, {CMD, 24'h3FFFFC});
        chk("b_rises", 32'(rises), 32'(RISES));

        // Second strobe at E+40 must be ignored
        flash_word = 32'hDEADBEEF;
        run_read(20'h12345, 40);
        chk("c_busy_len", 32'(n), 32'(BUSY));
        chk("c_rdata", rdata, 32'hEFBEADDE);
        chk("c_mosi", mosi_cap, {CMD, 24'h048D14});
        chk("c_rises", 32'(rises), 32'(RISES));
        repeat (3) @(negedge clk);
        chk("c_no_restart", 32'(rbusy), 32'd0);

        // rstrb held across completion: restart after one deselected cycle
        flash_word = 32'h01020304;
        @(negedge clk);
        word_address = 20'h00002;
        rstrb = 1'b1;
        n = 0;
        @(negedge clk);
        while (rbusy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("d_busy_len", 32'(n), 32'(BUSY));
        chk("d_rdata", rdata, 32'h04030201);
        chk("d_gap_csn", 32'(CS_N), 32'd1);
        flash_word = 32'hCAFEF00D;
        word_address = 20'h00003;
        @(negedge clk);
        rstrb = 1'b0;
        chk("d_restart", 32'(rbusy), 32'd1);
        n = 0;
        while (rbusy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("e_busy_len", 32'(n), 32'(BUSY));
        chk("e_rdata", rdata, 32'h0DF0FECA);
        chk("e_mosi", mosi_cap, {CMD, 24'h00000C});

        repeat (5) @(negedge clk);
        chk("clk_while_desel", 32'(bad_clk), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
